// File: rtl/lsu_pkg.sv
// Shared constants for the load/store initiator:
// funct3 codes, FSM encoding and lane geometry.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANE_BITS = 8;
  localparam int LANES     = 4;
  localparam int HALF_BITS = 2 * LANE_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD,
    ST_RMW,
    ST_WR,
    ST_RESP
  } state_e;

  // Size/alignment/legality check; the range check lives in the top.
  function automatic logic access_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b1;
    unique case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lo[0];
      F3_W:    bad = |lo;
      F3_BU:   bad = we;
      F3_HU:   bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering: extends loaded sub-words and
// merges store data into the addressed lanes.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] merged_o
);

  logic [4:0]           boff;
  logic [4:0]           hoff;
  logic [LANE_BITS-1:0] b;
  logic [HALF_BITS-1:0] h;
  logic                 sext;

  assign boff = {lane_i, 3'b000};
  assign hoff = {lane_i[1], 4'b0000};

  always_comb begin
    ldata_o  = '0;
    merged_o = word_i;
    b        = word_i[boff +: LANE_BITS];
    h        = word_i[hoff +: HALF_BITS];
    sext     = 1'b0;
    unique case (funct3_i)
      F3_B, F3_BU: begin
        sext    = (funct3_i == F3_B) & b[LANE_BITS-1];
        ldata_o = {{(32-LANE_BITS){sext}}, b};
        merged_o[boff +: LANE_BITS] = sdata_i[LANE_BITS-1:0];
      end
      F3_H, F3_HU: begin
        sext    = (funct3_i == F3_H) & h[HALF_BITS-1];
        ldata_o = {{(32-HALF_BITS){sext}}, h};
        merged_o[hoff +: HALF_BITS] = sdata_i[HALF_BITS-1:0];
      end
      default: begin
        ldata_o  = word_i;
        merged_o = sdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator for the word-wide
// Data_Memory port; sub-word stores use read-modify-write.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       WD,
  output logic              MemWrite,
  input  logic [31:0]       RD
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        accept;
  logic        req_err;
  logic        mem_act;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  lsu_byte_lane u_lane (
    .funct3_i (f3_q),
    .lane_i   (addr_q[1:0]),
    .word_i   (RD),
    .sdata_i  (wdata_q),
    .ldata_o  (ld_ext),
    .merged_o (merged)
  );

  assign accept  = req_valid & (state_q == ST_IDLE);
  assign req_err = access_err(req_we, req_funct3, req_addr[1:0])
                 | (req_addr >= ADDR_W'(MEM_BYTES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          we_d    = req_we;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)
            state_d = ST_RESP;
          else if (!req_we)
            state_d = ST_LD;
          else if (req_funct3 == F3_W)
            state_d = ST_WR;
          else
            state_d = ST_RMW;
        end
      end
      ST_LD: begin
        rdata_d = ld_ext;
        state_d = ST_RESP;
      end
      // wdata_q becomes the full merged word for the write beat
      ST_RMW: begin
        wdata_d = merged;
        state_d = ST_WR;
      end
      ST_WR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_act = (state_q == ST_LD)
                 | (state_q == ST_RMW)
                 | (state_q == ST_WR);

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  assign A        = mem_act ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign MemWrite = (state_q == ST_WR);
  assign WD       = MemWrite ? wdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a small
// word-wide data memory as responder.
module tb_lsu_mem_initiator;

  localparam int MEM_BYTES = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] A;
  logic [31:0] WD;
  logic        MemWrite;
  logic [31:0] RD;

  logic [31:0] mem [0:255];

  int checks;
  int errors;

  lsu_mem_initiator #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .A          (A),
    .WD         (WD),
    .MemWrite   (MemWrite),
    .RD         (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign RD = mem[A[9:2]];
  always @(posedge clk)
    if (MemWrite) mem[A[9:2]] <= WD;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          mw;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    int lat;
    int mw;
    logic got_err;
    logic [31:0] got_rd;
    lat = 0;
    mw = 0;
    got_err = 1'b0;
    got_rd = '0;
    @(negedge clk);
    chk({v.name, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (MemWrite) mw++;
      if (resp_valid) begin
        lat = c;
        got_err = resp_err;
        got_rd = resp_rdata;
        break;
      end
    end
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " err"}, {31'd0, got_err}, {31'd0, v.err});
    chk({v.name, " rdata"}, got_rd, v.rdata);
    chk({v.name, " memwrite cycles"}, mw, v.mw);
    @(posedge clk);
  endtask

  function automatic vec_t mk(string n, logic we, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd,
                              logic e, logic [31:0] rd, int lat, int mw);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.err = e; v.rdata = rd; v.lat = lat; v.mw = mw;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] rr;
    int r1, r2;
    logic [31:0] d1, d2;
    logic rdy_bad;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    vecs.push_back(mk("sw8",     1, 3'b010, 8,  32'hAAAA_BBBB, 0, 0, 2, 1));
    vecs.push_back(mk("lw8",     0, 3'b010, 8,  0, 0, 32'hAAAA_BBBB, 2, 0));
    vecs.push_back(mk("sw12",    1, 3'b010, 12, 32'hCCCC_DDDD, 0, 0, 2, 1));
    vecs.push_back(mk("sb13",    1, 3'b000, 13, 32'h0000_005A, 0, 0, 3, 1));
    vecs.push_back(mk("lw12a",   0, 3'b010, 12, 0, 0, 32'hCCCC_5ADD, 2, 0));
    vecs.push_back(mk("sb12",    1, 3'b000, 12, 32'h1234_5680, 0, 0, 3, 1));
    vecs.push_back(mk("lb12",    0, 3'b000, 12, 0, 0, 32'hFFFF_FF80, 2, 0));
    vecs.push_back(mk("lbu12",   0, 3'b100, 12, 0, 0, 32'h0000_0080, 2, 0));
    vecs.push_back(mk("lb13",    0, 3'b000, 13, 0, 0, 32'h0000_005A, 2, 0));
    vecs.push_back(mk("sh14",    1, 3'b001, 14, 32'h7777_BEEF, 0, 0, 3, 1));
    vecs.push_back(mk("lw12b",   0, 3'b010, 12, 0, 0, 32'hBEEF_5A80, 2, 0));
    vecs.push_back(mk("lh14",    0, 3'b001, 14, 0, 0, 32'hFFFF_BEEF, 2, 0));
    vecs.push_back(mk("lhu14",   0, 3'b101, 14, 0, 0, 32'h0000_BEEF, 2, 0));
    vecs.push_back(mk("lh12",    0, 3'b001, 12, 0, 0, 32'h0000_5A80, 2, 0));
    vecs.push_back(mk("lw6err",  0, 3'b010, 6,  0, 1, 0, 1, 0));
    vecs.push_back(mk("sh13err", 1, 3'b001, 13, 32'hFFFF_FFFF, 1, 0, 1, 0));
    vecs.push_back(mk("lbrange", 0, 3'b000, MEM_BYTES, 0, 1, 0, 1, 0));
    vecs.push_back(mk("f3_011",  0, 3'b011, 12, 0, 1, 0, 1, 0));
    vecs.push_back(mk("sbu_err", 1, 3'b100, 12, 32'h0000_0011, 1, 0, 1, 0));
    vecs.push_back(mk("lw12c",   0, 3'b010, 12, 0, 0, 32'hBEEF_5A80, 2, 0));

    rst = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset A", A, 32'd0);
    chk("reset WD", WD, 32'd0);
    chk("reset MemWrite", {31'd0, MemWrite}, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_req(vecs[i]);

    // Reset asserted while the sb sits in RMW.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 12; req_wdata = 32'h11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1;
    chk("rmw A before reset", A, 32'd12);
    rst = 1'b0;
    #1;
    chk("rst A", A, 32'd0);
    chk("rst WD", WD, 32'd0);
    chk("rst MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rr = mem[3];
    chk("word12 after reset", rr, 32'hBEEF_5A80);
    run_req(mk("lw_after_rst", 0, 3'b010, 12, 0, 0,
               32'hBEEF_5A80, 2, 0));

    // Back-to-back with req_valid held high.
    r1 = 0; r2 = 0; d1 = '0; d2 = '0; rdy_bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 8; req_wdata = '0;
    @(posedge clk);
    #1 req_addr = 12;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4) req_valid = 1'b0;
      if ((c == 1 || c == 2) && req_ready) rdy_bad = 1'b1;
      if (c == 3 && !req_ready) rdy_bad = 1'b1;
      if (resp_valid && r1 == 0) begin
        r1 = c; d1 = resp_rdata;
      end else if (resp_valid && r2 == 0) begin
        r2 = c; d2 = resp_rdata;
      end
    end
    chk("b2b first resp cycle", r1, 2);
    chk("b2b first rdata", d1, 32'hAAAA_BBBB);
    chk("b2b ready pattern", {31'd0, rdy_bad}, 32'd0);
    chk("b2b second resp cycle", r2, 5);
    chk("b2b second rdata", d2, 32'hBEEF_5A80);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
